adder_rr_arbiter: RTL

- Shares one 32-bit `carry_skip_adder` instance between NUM_REQ requesters.
- Each requester has a valid/ready request channel. A single response channel returns the sum tagged with the requester ID.
- Arbitration is round-robin. One operation is in flight at a time, sequenced by a 3-state FSM.
- Sits between client blocks and the shared adder datapath.

---
 rtl/adder_rr_arbiter.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/adder_rr_arbiter.sv
// rtl/adder_rr_arbiter.sv - round-robin arbiter sharing one 32-bit carry-skip adder
//
// adder_rr_arbiter: NUM_REQ valid/ready request channels feed a single shared
// adder. One operation is in flight at a time (IDLE -> EXEC -> RESP). The
// response returns the sum and the issuing requester's index.
//
// Ports:
//   i_clk        clock, rising edge
//   i_rst        synchronous active-high reset
//   i_req_valid  [NUM_REQ]      request valid per requester
//   o_req_ready  [NUM_REQ]      one-hot grant in IDLE, zero otherwise
//   i_req_a      [NUM_REQ*32]   operand A, requester k at [k*32 +: 32]
//   i_req_b      [NUM_REQ*32]   operand B, same packing
//   o_rsp_valid                 response valid (registered)
//   i_rsp_ready                 response consumer ready
//   o_rsp_sum    [32]           (A + B) mod 2**32
//   o_rsp_id     [ID_W]         requester index of the operation
//   o_rsp_ovf                   signed overflow, only with ADDER_ARB_OVF_EN
//
// Optional feature macro: ADDER_ARB_OVF_EN (adds o_rsp_ovf).
//
// carry_skip_adder: 32-bit adder built from 4-bit ripple blocks with a
// block-propagate skip path. Ports: a_i, b_i (32), sum_o (32).

module carry_skip_adder (
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    output logic [31:0] sum_o
);
    logic [31:0] p;
    logic [7:0]  blk_c;
    logic        rc;

    assign p = a_i ^ b_i;

    always_comb begin
        blk_c = '0;
        sum_o = '0;
        rc    = 1'b0;
        for (int blk = 0; blk < 8; blk++) begin
            rc = blk_c[blk];
            for (int j = 0; j < 4; j++) begin
                sum_o[blk*4+j] = p[blk*4+j] ^ rc;
                rc = (a_i[blk*4+j] & b_i[blk*4+j]) | (rc & p[blk*4+j]);
            end
            // A fully propagating block passes its carry-in straight through.
            if (blk < 7) begin
                blk_c[blk+1] = (&p[blk*4 +: 4]) ? blk_c[blk] : rc;
            end
        end
    end
endmodule

module adder_rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2,
    parameter int DATA_W  = 32
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic [NUM_REQ-1:0]        i_req_valid,
    output logic [NUM_REQ-1:0]        o_req_ready,
    input  logic [NUM_REQ*DATA_W-1:0] i_req_a,
    input  logic [NUM_REQ*DATA_W-1:0] i_req_b,
    output logic                      o_rsp_valid,
    input  logic                      i_rsp_ready,
    output logic [DATA_W-1:0]         o_rsp_sum,
    output logic [ID_W-1:0]           o_rsp_id
`ifdef ADDER_ARB_OVF_EN
    ,
    output logic                      o_rsp_ovf
`endif
);
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t              state_q;
    logic [ID_W-1:0]     rr_q;
    logic [ID_W-1:0]     rr_d;
    logic [DATA_W-1:0]   op_a_q;
    logic [DATA_W-1:0]   op_b_q;
    logic [ID_W-1:0]     id_q;
    logic [DATA_W-1:0]   sum_q;
    logic                rsp_valid_q;
    logic [31:0]         adder_sum;

    logic                grant_found;
    logic [ID_W-1:0]     grant_idx;
    int                  scan_idx;

    // Scan upward from the pointer with wrap; first valid requester wins.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        scan_idx    = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            scan_idx = int'(rr_q) + i;
            if (scan_idx >= NUM_REQ) begin
                scan_idx = scan_idx - NUM_REQ;
            end
            if (!grant_found && i_req_valid[scan_idx]) begin
                grant_found = 1'b1;
                grant_idx   = ID_W'(scan_idx);
            end
        end
    end

    always_comb begin
        o_req_ready = '0;
        if (state_q == ST_IDLE && !i_rst && grant_found) begin
            o_req_ready = NUM_REQ'(1) << grant_idx;
        end
    end

    always_comb begin
        rr_d = grant_idx + ID_W'(1);
        if (grant_idx == ID_W'(NUM_REQ - 1)) begin
            rr_d = '0;
        end
    end

    carry_skip_adder u_adder (
        .a_i   (op_a_q),
        .b_i   (op_b_q),
        .sum_o (adder_sum)
    );

`ifdef ADDER_ARB_OVF_EN
    logic ovf_q;
    assign o_rsp_ovf = ovf_q;
`endif

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q     <= ST_IDLE;
            rr_q        <= '0;
            op_a_q      <= '0;
            op_b_q      <= '0;
            id_q        <= '0;
            sum_q       <= '0;
            rsp_valid_q <= 1'b0;
`ifdef ADDER_ARB_OVF_EN
            ovf_q       <= 1'b0;
`endif
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (grant_found) begin
                        op_a_q  <= i_req_a[int'(grant_idx)*DATA_W +: DATA_W];
                        op_b_q  <= i_req_b[int'(grant_idx)*DATA_W +: DATA_W];
                        id_q    <= grant_idx;
                        rr_q    <= rr_d;
                        state_q <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    sum_q       <= adder_sum;
                    rsp_valid_q <= 1'b1;
`ifdef ADDER_ARB_OVF_EN
                    ovf_q       <= (op_a_q[31] == op_b_q[31]) &&
                                   (adder_sum[31] != op_a_q[31]);
`endif
                    state_q     <= ST_RESP;
                end
                ST_RESP: begin
                    if (i_rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        state_q     <= ST_IDLE;
                    end
                end
                default: begin
                    state_q     <= ST_IDLE;
                    rsp_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign o_rsp_valid = rsp_valid_q;
    assign o_rsp_sum   = sum_q;
    assign o_rsp_id    = id_q;
endmodule
